// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, PC-select encodings and fetch-state type
package cpu_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [1:0] PS_HOLD = 2'd0;
  localparam logic [1:0] PS_INC  = 2'd1;
  localparam logic [1:0] PS_REG  = 2'd2;
  localparam logic [1:0] PS_BR   = 2'd3;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_READY = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next-PC selector and adders
module pc_next
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      ps,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] constant,
  input  logic [XLEN-1:0] reg_a,
  output logic [XLEN-1:0] next_pc
);

  // Select the candidate PC; the branch offset is a word count, hence the shift by 2
  always_comb begin
    next_pc = pc;
    case (ps)
      PS_INC:  next_pc = pc + 64'd4;
      PS_REG:  next_pc = reg_a;
      PS_BR:   next_pc = pc_sel ? (pc + (constant << 2)) : reg_a;
      default: next_pc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC register, fetch FSM, instruction register
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      PS,
  input  logic            PCSel,
  input  logic [XLEN-1:0] constant,
  input  logic [XLEN-1:0] reg_a,
  input  logic            pc_update,
  input  logic            EN_PC,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] I,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_link,
  output logic            fault,
  output logic [31:0]     retired
);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] instr_q;
  logic            valid_q;
  logic            req_q;
  logic [31:0]     retired_q;
  logic [XLEN-1:0] next_pc;
  logic            ack_fire;
  logic            update_fire;
  logic            misaligned;

  pc_next u_pc_next (
    .pc       (pc_q),
    .ps       (PS),
    .pc_sel   (PCSel),
    .constant (constant),
    .reg_a    (reg_a),
    .next_pc  (next_pc)
  );

  // An ack only counts while our own request is up, so a stale ack after reset is dropped
  assign ack_fire    = (state == ST_FETCH) && req_q && imem_ack;
  assign update_fire = (state == ST_READY) && pc_update && (PS != PS_HOLD);
  assign misaligned  = |next_pc[1:0];

  assign imem_addr   = pc_q;
  assign imem_req    = req_q;
  assign I           = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_link     = EN_PC ? (pc_q + 64'd4) : '0;
  assign retired     = retired_q;

  // Fetch state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and fault flag
  always_comb begin
    state_next = state;
    fault      = 1'b0;
    case (state)
      ST_FETCH: if (ack_fire) state_next = ST_READY;
      ST_READY: if (update_fire) state_next = misaligned ? ST_FAULT : ST_FETCH;
      ST_FAULT: begin
        state_next = ST_FAULT;
        fault      = 1'b1;
      end
      default:  state_next = ST_FETCH;
    endcase
  end

  // PC, instruction register, request and retire counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      req_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      if (ack_fire) begin
        instr_q <= imem_rdata;
        valid_q <= 1'b1;
        req_q   <= 1'b0;
      end else if (state == ST_FETCH) begin
        // Raises the request in the first cycle after reset release
        req_q <= 1'b1;
      end
      if (update_fire) begin
        pc_q      <= next_pc;
        valid_q   <= 1'b0;
        retired_q <= retired_q + 32'd1;
        req_q     <= !misaligned;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the control unit. Holds the 64-bit program counter, fetches 32-bit instructions from instruction memory over a req/ack handshake, and presents them with a valid flag. Applies the control unit's PC-select (`PS`, `PCSel`, `constant`) to compute the next PC, and supplies PC+4 for branch-with-link writeback.

## Interface
- `RESET_PC`, default 64'h0: PC loaded on reset.
- `clock`  in  1  sole clock; rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 = in reset.
- `PS`  in  2  next-PC select:
  - 0 = hold
  - 1 = PC+4
  - 2 = register
  - 3 = branch
- `PCSel`  in  1  when `PS`=3: 1 = PC + (`constant`<<2), 0 = `reg_a`.
- `constant`  in  64  sign-extended word offset from the control unit.
- `reg_a`  in  64  register-file A bus, used as the target for BR.
- `pc_update`  in  1  one-cycle strobe from the control unit: instruction complete, apply `PS`.
- `EN_PC`  in  1  drive link value onto the data bus.
- `imem_addr`  out  64  fetch address.
- `imem_req`  out  1  fetch request.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word.
- `I`  out  32  latched instruction register.
- `instr_valid`  out  1  `I` is valid for the current PC.
- `pc`  out  64  current PC.
- `pc_link`  out  64  PC+4 when `EN_PC`=1, else 0.
- `fault`  out  1  sticky misaligned-PC fault.
- `retired`  out  32  count of completed instructions.

## Operation
- **States:** FETCH, READY, FAULT.
- **Reset values:**
  - PC=`RESET_PC`, `I`=0, `instr_valid`=0, `imem_req`=0, `fault`=0, `retired`=0, state=FETCH.
- **FETCH:**
  - Drive `imem_req`=1 and `imem_addr`=PC; hold both stable until `imem_ack`.
  - On `imem_ack`: latch `imem_rdata` into `I`, set `instr_valid`=1, go to READY.
  - `pc_update` is ignored in FETCH.
- **READY:**
  - `I` and `pc` are held stable; `imem_req`=0.
  - On `pc_update`, next PC is:
    - `PS`=1: PC+4.
    - `PS`=2: `reg_a`.
    - `PS`=3: `PCSel` ? PC+(`constant`<<2) : `reg_a`.
    - `PS`=0: PC unchanged; stay in READY, no refetch, `retired` unchanged.
  - For `PS`≠0: `retired`+1 (wraps at 2^32), `instr_valid` cleared, go to FETCH with the new PC.
  - If the new PC has [1:0]≠0: go to FAULT instead of FETCH.
- **Arithmetic:** all 64-bit modulo 2^64. The shift is a logical left shift of the signed `constant` by 2.
- **FAULT:** `fault`=1, `imem_req`=0, `instr_valid`=0, PC holds the offending value. FAULT is exited only by reset.
- **Link value:** `pc_link` = PC+4 of the current instruction, combinational on `EN_PC`.

## Timing
- **First fetch:** `imem_req` rises in the first clock after `reset` deasserts (synchronously released).
- **Fetch latency:** ack in cycle n gives `I`/`instr_valid` high in cycle n+1.
  - Zero-wait memory (ack in the same cycle as req) gives 2 cycles from `pc_update` to valid.
- **`pc_update` in cycle n (READY):**
  - `pc` updates at the end of cycle n.
  - `instr_valid`=0 and `imem_req`=1 in cycle n+1.
- **Reset mid-fetch:** returns immediately to reset values. The outstanding ack is discarded, because FETCH after reset only accepts an ack while its own request is asserted.
- **`pc_update` coincident with `imem_ack`:** this happens only in FETCH; `pc_update` is ignored and the ack is honoured.

## Structure
- **Shared package `cpu_pkg`:**
  - PS encoding constants: `PS_HOLD`, `PS_INC`, `PS_REG`, `PS_BR`.
  - Fetch-state enum.
  - Word size constants (64-bit datapath, 32-bit instruction).
- **Sub-module `pc_next`:** combinational next-PC selector/adder taking PC, `PS`, `PCSel`, `constant`, `reg_a`. The FSM, PC register, instruction register and counter stay in `fetch_unit`.

## Test plan
- **Reset and first fetch:** reset low, then high with `RESET_PC`=0 and memory ack after 3 cycles returning 32'h91000421.
  - `imem_addr`=0, `imem_req` held 3 cycles, `I`=32'h91000421, `instr_valid`=1 the next cycle.
- **Sequential:** `PS`=1, `pc_update` at PC=0x10.
  - PC=0x14, refetch at 0x14, `retired` increments by 1.
- **Branch:** `PS`=3, `PCSel`=1, `constant`=-2 at PC=0x20.
  - PC=0x18.
- **BR and hold:**
  - `PS`=2, `reg_a`=0x400 gives PC=0x400.
  - `PS`=0 with `pc_update` gives PC unchanged, `instr_valid` stays 1, no `imem_req`.
- **Fault and link:**
  - `PS`=2, `reg_a`=0x402 gives `fault`=1, `imem_req`=0 permanently until reset.
  - `EN_PC`=1 at PC=0x30 gives `pc_link`=0x34.
- **Reset mid-fetch and ignored update:**
  - Reset asserted during a pending req gives all outputs at reset values with no stale `I` latched.
  - `pc_update` pulsed during FETCH leaves PC unchanged.
